cam_frame_capture_ctrl: RTL

CAM_FRAME_CAPTURE_CTRL -- requirements
Module: cam_frame_capture_ctrl

---
 rtl/cam_frame_capture_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cam_frame_capture_ctrl.sv
// Camera frame capture controller: windows the camera pixel stream and emits linear frame-buffer writes.
// Optional macro CAM_CAPTURE_DECIMATE_EN keeps only even-offset pixels (2x2 decimation).
module cam_frame_capture_ctrl #(
  parameter logic [12:0] H_START  = 13'd160,
  parameter logic [12:0] V_START  = 13'd45,
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480
) (
  input  logic        CCD_PIXCLK,
  input  logic        RESET_SYS_N,
  input  logic        cap_start,
  input  logic        cap_continuous,
  input  logic        cap_abort,
  input  logic        CCD_FVAL,
  input  logic        sCCD_DVAL,
  input  logic [12:0] cam_xcont,
  input  logic [12:0] cam_ycont,
  input  logic [7:0]  cam_red,
  input  logic [7:0]  cam_green,
  input  logic [7:0]  cam_blue,
  input  logic        wr_ready,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [23:0] wr_data,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  output logic [7:0]  frame_count
);

`ifdef CAM_CAPTURE_DECIMATE_EN
  localparam int NPIX = (H_ACTIVE / 2) * (V_ACTIVE / 2);
`else
  localparam int NPIX = H_ACTIVE * V_ACTIVE;
`endif
  localparam logic [18:0] ADDR_MAX = 19'(NPIX - 1);
  localparam logic [13:0] H_LO = {1'b0, H_START};
  localparam logic [13:0] H_HI = H_LO + 14'(H_ACTIVE);
  localparam logic [13:0] V_LO = {1'b0, V_START};
  localparam logic [13:0] V_HI = V_LO + 14'(V_ACTIVE);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        fval_q;
  logic [18:0] addr_q, addr_d;
  logic        wr_en_q;
  logic [18:0] wr_addr_q;
  logic [23:0] wr_data_q;
  logic        overrun_q, overrun_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        fval_rise, fval_fall, in_win, phase_ok, qual, clr_ovr;

  assign fval_rise = CCD_FVAL & ~fval_q;
  assign fval_fall = ~CCD_FVAL & fval_q;
  assign in_win = ({1'b0, cam_xcont} >= H_LO) && ({1'b0, cam_xcont} < H_HI) &&
                  ({1'b0, cam_ycont} >= V_LO) && ({1'b0, cam_ycont} < V_HI);
`ifdef CAM_CAPTURE_DECIMATE_EN
  // Offset parity from the window origin equals the xor of the low bits.
  assign phase_ok = ~(cam_xcont[0] ^ H_START[0]) & ~(cam_ycont[0] ^ V_START[0]);
`else
  assign phase_ok = 1'b1;
`endif
  assign qual = (state_q == S_CAPTURE) & sCCD_DVAL & in_win & phase_ok & ~cap_abort;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fcnt_d  = fcnt_q;
    clr_ovr = 1'b0;
    if (qual && addr_q != ADDR_MAX) addr_d = addr_q + 19'd1;
    if (cap_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (cap_start) begin
          state_d = S_ARMED;
          addr_d  = '0;
          clr_ovr = 1'b1;
        end
        S_ARMED:   if (fval_rise) state_d = S_CAPTURE;
        S_CAPTURE: if (fval_fall) begin
          state_d = S_DONE;
          fcnt_d  = fcnt_q + 8'd1;
        end
        S_DONE: begin
          state_d = cap_continuous ? S_ARMED : S_IDLE;
          addr_d  = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
    // A dropped write is only visible as the registered strobe meeting a low ready.
    overrun_d = overrun_q | (wr_en_q & ~wr_ready);
    if (clr_ovr) overrun_d = 1'b0;
  end

  always_ff @(posedge CCD_PIXCLK) begin
    if (!RESET_SYS_N) begin
      state_q   <= S_IDLE;
      fval_q    <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      overrun_q <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      fval_q    <= CCD_FVAL;
      addr_q    <= addr_d;
      wr_en_q   <= qual;
      overrun_q <= overrun_d;
      fcnt_q    <= fcnt_d;
      if (qual) begin
        wr_addr_q <= addr_q;
        wr_data_q <= {cam_red, cam_green, cam_blue};
      end
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign frame_done  = (state_q == S_DONE);
  assign overrun     = overrun_q;
  assign frame_count = fcnt_q;

endmodule
